// File: rtl/axi4_pkg.sv
// rtl/axi4_pkg.sv - shared AXI4 encodings and slave FSM state type
package axi4_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR_DATA,
    S_WR_RESP
  } state_e;

endpackage

// File: rtl/axi4_if.sv
// rtl/axi4_if.sv - full AXI4 channel bundle with master/slave views
interface axi4_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 5
) ();
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awlock;
  logic [3:0]              awcache;
  logic [2:0]              awprot;
  logic [3:0]              awqos;
  logic [3:0]              awregion;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arlock;
  logic [3:0]              arcache;
  logic [2:0]              arprot;
  logic [3:0]              arqos;
  logic [3:0]              arregion;
  logic                    arvalid;
  logic                    arready;

  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi4_burst_addr_gen.sv
// rtl/axi4_burst_addr_gen.sv - combinational next-beat address for FIXED/INCR/WRAP bursts
module axi4_burst_addr_gen
  import axi4_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [7:0]            i_len,
  input  logic [2:0]            i_size,
  input  logic [1:0]            i_burst,
  output logic [ADDR_WIDTH-1:0] o_next_addr
);
  logic [ADDR_WIDTH-1:0] w_step;
  logic [ADDR_WIDTH-1:0] w_incr;
  logic [ADDR_WIDTH-1:0] w_mask;
  logic [2:0]            w_wrap_sh;

  always_comb begin
    w_step = ADDR_WIDTH'(1) << i_size;
    w_incr = i_addr + w_step;
    case (i_len)
      8'd1:    w_wrap_sh = 3'd1;
      8'd3:    w_wrap_sh = 3'd2;
      8'd7:    w_wrap_sh = 3'd3;
      8'd15:   w_wrap_sh = 3'd4;
      default: w_wrap_sh = 3'd0;
    endcase
    w_mask = (w_step << w_wrap_sh) - ADDR_WIDTH'(1);
    o_next_addr = w_incr;
    case (burst_e'(i_burst))
      BURST_FIXED: o_next_addr = i_addr;
      // Illegal WRAP lengths fall back to INCR.
      BURST_WRAP:  if (w_wrap_sh != 3'd0) o_next_addr = (i_addr & ~w_mask) | (w_incr & w_mask);
      default:     o_next_addr = w_incr;
    endcase
  end
endmodule

// File: rtl/axi4_sram_slave.sv
// rtl/axi4_sram_slave.sv - AXI4 burst slave over a single-port byte-enabled word RAM
module axi4_sram_slave
  import axi4_pkg::*;
#(
  parameter int AXI4_ADDRESS_WIDTH = 32,
  parameter int AXI4_DATA_WIDTH    = 32,
  parameter int AXI4_ID_WIDTH      = 5,
  parameter int MEM_ADDR_BITS      = 10
) (
  input  logic  clk_i,
  input  logic  rst_i,
  axi4_if.slave s
);
  localparam int STRB_W = AXI4_DATA_WIDTH / 8;
  localparam int B      = $clog2(STRB_W);

  logic [AXI4_DATA_WIDTH-1:0]    r_mem [2**MEM_ADDR_BITS];
  state_e                        r_state;
  logic                          r_last_wr;
  logic [AXI4_ADDRESS_WIDTH-1:0] r_addr;
  logic [7:0]                    r_len;
  logic [2:0]                    r_size;
  logic [1:0]                    r_burst;
  logic [7:0]                    r_beat;
  logic                          r_rvalid;
  logic                          r_rlast;
  logic [AXI4_DATA_WIDTH-1:0]    r_rdata;
  logic [AXI4_ID_WIDTH-1:0]      r_rid;
  logic                          r_wready;
  logic                          r_bvalid;
  logic [AXI4_ID_WIDTH-1:0]      r_bid;

  logic                          w_grant_rd;
  logic                          w_arready;
  logic                          w_awready;
  logic                          w_wr_beat;
  logic [AXI4_ADDRESS_WIDTH-1:0] w_gen_addr;
  logic [7:0]                    w_gen_len;
  logic [2:0]                    w_gen_size;
  logic [1:0]                    w_gen_burst;
  logic [AXI4_ADDRESS_WIDTH-1:0] w_next_addr;
  logic [MEM_ADDR_BITS-1:0]      w_ar_idx;
  logic [MEM_ADDR_BITS-1:0]      w_cur_idx;

  // Contention alternates: the side not granted last wins.
  assign w_grant_rd = s.arvalid && (!s.awvalid || r_last_wr);
  assign w_arready  = !rst_i && (r_state == S_IDLE) && w_grant_rd;
  assign w_awready  = !rst_i && (r_state == S_IDLE) && s.awvalid && !w_grant_rd;
  assign w_wr_beat  = (r_state == S_WR_DATA) && r_wready && s.wvalid;
  assign w_ar_idx   = s.araddr[MEM_ADDR_BITS+B-1:B];
  assign w_cur_idx  = r_addr[MEM_ADDR_BITS+B-1:B];

  always_comb begin
    w_gen_addr  = r_addr;
    w_gen_len   = r_len;
    w_gen_size  = r_size;
    w_gen_burst = r_burst;
    if (r_state == S_IDLE) begin
      if (w_grant_rd) begin
        w_gen_addr  = s.araddr;
        w_gen_len   = s.arlen;
        w_gen_size  = s.arsize;
        w_gen_burst = s.arburst;
      end else begin
        w_gen_addr  = s.awaddr;
        w_gen_len   = s.awlen;
        w_gen_size  = s.awsize;
        w_gen_burst = s.awburst;
      end
    end
  end

  axi4_burst_addr_gen #(.ADDR_WIDTH(AXI4_ADDRESS_WIDTH)) u_addr_gen (
    .i_addr      (w_gen_addr),
    .i_len       (w_gen_len),
    .i_size      (w_gen_size),
    .i_burst     (w_gen_burst),
    .o_next_addr (w_next_addr)
  );

  always_ff @(posedge clk_i) begin
    if (w_wr_beat) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (s.wstrb[i]) r_mem[w_cur_idx][8*i +: 8] <= s.wdata[8*i +: 8];
      end
    end
  end

  // On reads r_addr holds the next beat to fetch; on writes, the beat being written.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_last_wr <= 1'b1;
      r_addr    <= '0;
      r_len     <= '0;
      r_size    <= '0;
      r_burst   <= '0;
      r_beat    <= '0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rdata   <= '0;
      r_rid     <= '0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bid     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_arready) begin
            r_last_wr <= 1'b0;
            r_rid     <= s.arid;
            r_addr    <= w_next_addr;
            r_len     <= s.arlen;
            r_size    <= s.arsize;
            r_burst   <= s.arburst;
            r_beat    <= '0;
            r_rdata   <= r_mem[w_ar_idx];
            r_rvalid  <= 1'b1;
            r_rlast   <= (s.arlen == 8'd0);
            r_state   <= S_RD;
          end else if (w_awready) begin
            r_last_wr <= 1'b1;
            r_bid     <= s.awid;
            r_addr    <= s.awaddr;
            r_len     <= s.awlen;
            r_size    <= s.awsize;
            r_burst   <= s.awburst;
            r_beat    <= '0;
            r_wready  <= 1'b1;
            r_state   <= S_WR_DATA;
          end
        end
        S_RD: begin
          if (r_rvalid && s.rready) begin
            if (r_rlast) begin
              r_rvalid <= 1'b0;
              r_rlast  <= 1'b0;
              r_state  <= S_IDLE;
            end else begin
              r_rdata <= r_mem[w_cur_idx];
              r_addr  <= w_next_addr;
              r_beat  <= r_beat + 8'd1;
              r_rlast <= ((r_beat + 8'd1) == r_len);
            end
          end
        end
        S_WR_DATA: begin
          if (w_wr_beat) begin
            r_addr <= w_next_addr;
            r_beat <= r_beat + 8'd1;
            if (r_beat == r_len) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_state  <= S_WR_RESP;
            end
          end
        end
        S_WR_RESP: begin
          if (s.bready) begin
            r_bvalid <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s.awready = w_awready;
  assign s.arready = w_arready;
  assign s.wready  = r_wready;
  assign s.bvalid  = r_bvalid;
  assign s.bid     = r_bid;
  assign s.bresp   = RESP_OKAY;
  assign s.rvalid  = r_rvalid;
  assign s.rlast   = r_rlast;
  assign s.rdata   = r_rdata;
  assign s.rid     = r_rid;
  assign s.rresp   = RESP_OKAY;
endmodule

// File: tb/tb_axi4_sram_slave.sv
// tb/tb_axi4_sram_slave.sv - directed self-checking bench for axi4_sram_slave
module tb_axi4_sram_slave;
  import axi4_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [31:0] exp_q [$];

  axi4_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(5)) bus ();

  axi4_sram_slave #(
    .AXI4_ADDRESS_WIDTH(32), .AXI4_DATA_WIDTH(32), .AXI4_ID_WIDTH(5), .MEM_ADDR_BITS(10)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .s     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ar_req(input logic [31:0] addr, input logic [4:0] id, input logic [7:0] len,
                        input logic [1:0] burst, input bit hold);
    int n = 0;
    bus.araddr = addr; bus.arid = id; bus.arlen = len; bus.arsize = 3'd2; bus.arburst = burst;
    bus.arvalid = 1'b1;
    #1;
    while (!bus.arready && n < 50) begin @(posedge clk); #2; n++; end
    check("ar_wait", bus.arready, 1);
    @(posedge clk); #1;
    if (!hold) bus.arvalid = 1'b0;
    check("rd_latency", bus.rvalid, 1);
  endtask

  task automatic r_beats(input logic [4:0] id, input int len, input bit toggle);
    int beat = 0;
    int cyc = 0;
    while (beat <= len && cyc < 100) begin
      bus.rready = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      #1;
      if (bus.rvalid) begin
        if (bus.rready) begin
          check("r_data", bus.rdata, exp_q[beat]);
          check("r_last", bus.rlast, (beat == len));
          check("r_id", bus.rid, id);
          check("r_resp", bus.rresp, RESP_OKAY);
          beat++;
        end else begin
          check("r_hold", bus.rdata, exp_q[beat]);
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.rready = 1'b0;
    check("r_beats_done", beat, len + 1);
  endtask

  task automatic aw_req(input logic [31:0] addr, input logic [4:0] id, input logic [7:0] len,
                        input logic [1:0] burst, input bit hold);
    int n = 0;
    bus.awaddr = addr; bus.awid = id; bus.awlen = len; bus.awsize = 3'd2; bus.awburst = burst;
    bus.awvalid = 1'b1;
    #1;
    while (!bus.awready && n < 50) begin @(posedge clk); #2; n++; end
    check("aw_wait", bus.awready, 1);
    @(posedge clk); #1;
    if (!hold) bus.awvalid = 1'b0;
  endtask

  task automatic w_beats(input logic [3:0] strb, input int len);
    for (int i = 0; i <= len; i++) begin
      int n = 0;
      bus.wdata = exp_q[i]; bus.wstrb = strb; bus.wlast = (i == len); bus.wvalid = 1'b1;
      #1;
      while (!bus.wready && n < 50) begin @(posedge clk); #2; n++; end
      check("w_wait", bus.wready, 1);
      @(posedge clk); #1;
    end
    bus.wvalid = 1'b0;
    bus.wlast = 1'b0;
  endtask

  task automatic b_resp(input logic [4:0] id);
    int n = 0;
    bus.bready = 1'b1;
    #1;
    check("b_no_wready", bus.wready, 0);
    while (!bus.bvalid && n < 50) begin @(posedge clk); #2; n++; end
    check("b_valid", bus.bvalid, 1);
    check("b_id", bus.bid, id);
    check("b_resp", bus.bresp, RESP_OKAY);
    @(posedge clk); #1;
    bus.bready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.awlock = 1'b0; bus.awcache = '0; bus.awprot = '0; bus.awqos = '0; bus.awregion = '0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
    bus.arlock = 1'b0; bus.arcache = '0; bus.arprot = '0; bus.arqos = '0; bus.arregion = '0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.rready = 1'b0;
    bus.arvalid = 1'b1; bus.awvalid = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_arready", bus.arready, 0);
    check("rst_awready", bus.awready, 0);
    check("rst_wready", bus.wready, 0);
    check("rst_bvalid", bus.bvalid, 0);
    check("rst_rvalid", bus.rvalid, 0);
    check("rst_rlast", bus.rlast, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_rid", bus.rid, 0);
    check("rst_bid", bus.bid, 0);
    bus.arvalid = 1'b0; bus.awvalid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // single write then read
    exp_q = '{32'hDEADBEEF};
    aw_req(32'h100, 5'h03, 8'd0, BURST_INCR, 0);
    w_beats(4'hF, 0);
    b_resp(5'h03);
    ar_req(32'h100, 5'h12, 8'd0, BURST_INCR, 0);
    r_beats(5'h12, 0, 0);

    // INCR burst with read back-pressure
    exp_q = '{32'h11, 32'h22, 32'h33, 32'h44};
    aw_req(32'h40, 5'h04, 8'd3, BURST_INCR, 0);
    w_beats(4'hF, 3);
    b_resp(5'h04);
    ar_req(32'h40, 5'h05, 8'd3, BURST_INCR, 0);
    r_beats(5'h05, 3, 1);

    // WRAP read starting mid-window: 0x48, 0x4C, 0x40, 0x44
    exp_q = '{32'h33, 32'h44, 32'h11, 32'h22};
    ar_req(32'h48, 5'h06, 8'd3, BURST_WRAP, 0);
    r_beats(5'h06, 3, 0);

    // byte strobes
    exp_q = '{32'hAABBCCDD};
    aw_req(32'h0, 5'h07, 8'd0, BURST_INCR, 0);
    w_beats(4'hF, 0);
    b_resp(5'h07);
    exp_q = '{32'h11223344};
    aw_req(32'h0, 5'h08, 8'd0, BURST_INCR, 0);
    w_beats(4'b0101, 0);
    b_resp(5'h08);
    exp_q = '{32'hAA22CC44};
    ar_req(32'h0, 5'h09, 8'd0, BURST_INCR, 0);
    r_beats(5'h09, 0, 0);

    // arbitration from reset with both sides held
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.awaddr = 32'h100; bus.awid = 5'h1B; bus.awlen = 8'd0; bus.awsize = 3'd2;
    bus.awburst = BURST_INCR; bus.awvalid = 1'b1;
    bus.araddr = 32'h100; bus.arid = 5'h15; bus.arlen = 8'd0; bus.arsize = 3'd2;
    bus.arburst = BURST_INCR; bus.arvalid = 1'b1;
    #1;
    check("arb1_arready", bus.arready, 1);
    check("arb1_awready", bus.awready, 0);
    exp_q = '{32'hDEADBEEF};
    ar_req(32'h100, 5'h15, 8'd0, BURST_INCR, 1);
    r_beats(5'h15, 0, 0);
    #1;
    check("arb2_arready", bus.arready, 0);
    check("arb2_awready", bus.awready, 1);
    exp_q = '{32'h600DF00D};
    aw_req(32'h100, 5'h1B, 8'd0, BURST_INCR, 1);
    w_beats(4'hF, 0);
    b_resp(5'h1B);
    #1;
    check("arb3_arready", bus.arready, 1);
    check("arb3_awready", bus.awready, 0);
    bus.awvalid = 1'b0;
    ar_req(32'h100, 5'h15, 8'd0, BURST_INCR, 0);
    r_beats(5'h15, 0, 0);

    // reset in the middle of a len=7 read
    exp_q = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8};
    aw_req(32'h300, 5'h0A, 8'd7, BURST_INCR, 0);
    w_beats(4'hF, 7);
    b_resp(5'h0A);
    ar_req(32'h300, 5'h0B, 8'd7, BURST_INCR, 0);
    bus.rready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("mid_data", bus.rdata, exp_q[i]);
      @(posedge clk); #1;
    end
    bus.rready = 1'b0;
    check("mid_beat2", bus.rdata, 32'h3);
    bus.arvalid = 1'b1;
    rst = 1'b1;
    #1;
    check("mid_rst_rvalid", bus.rvalid, 0);
    check("mid_rst_rlast", bus.rlast, 0);
    check("mid_rst_arready", bus.arready, 0);
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_rvalid", bus.rvalid, 0);
    exp_q = '{32'h600DF00D};
    ar_req(32'h100, 5'h11, 8'd0, BURST_INCR, 0);
    r_beats(5'h11, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
